riscv_fetch_queue: RTL and testbench
====================================

// Module: riscv_fetch_queue
// PURPOSE
//  Instruction-fetch front end feeding the pipelined RISC_V core's IF stage.
//  Issues in-order word fetches to an instruction memory with variable latency,
//  buffers returned instructions with their PC in a DEPTH-entry FIFO, and handles
//  branch/jump redirects from the core by flushing the queue and dropping stale responses.
// PARAMETERS
//  DEPTH     4             FIFO entries; also the cap on (FIFO occupancy + outstanding requests); power of 2, >=2
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  fetch address (word aligned)
//  imem_resp_valid in   1   memory returns one instruction (in request order)
//  imem_resp_data  in   32  returned instruction word
//  inst_valid      out  1   FIFO head valid toward core
//  inst_ready      in   1   core consumes head (low = IF stall)
//  inst_data       out  32  head instruction
//  inst_pc         out  32  PC of head instruction
//  redirect_valid  in   1   core resolved taken branch/jump
//  redirect_pc     in   32  new fetch PC (word aligned)
// BEHAVIOUR
//  Reset (rst=0, async): state=BOOT, fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty,
//   outstanding=0, drop_cnt=0; imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC,
//   inst_data=0, inst_pc=0. Reset mid-operation discards everything; late responses after reset are ignored only via the bound below.
//  FSM: BOOT -> RUN after first clock with rst=1.
//   RUN -> FLUSH on redirect_valid when stale requests remain (outstanding minus same-cycle resp > 0).
//   RUN -> RUN on redirect_valid when none remain. FLUSH -> RUN when drop_cnt reaches 0.
//   Redirect in FLUSH: reload fetch_pc/resp_pc; drop_cnt keeps counting all still-outstanding requests.
//  Request: imem_req_valid = (state==RUN) & !redirect_valid & (count+outstanding < DEPTH).
//   imem_req_addr = fetch_pc. On valid&ready: fetch_pc += 4 (mod 2^32 wrap), outstanding++.
//  Response: each imem_resp_valid decrements outstanding. If drop_cnt>0: drop_cnt--, discard.
//   Else if redirect_valid same cycle: discard. Else push {resp_pc, data}, resp_pc += 4.
//   Credit rule guarantees push never overflows; a push into a full FIFO is a design error (assert).
//  Dequeue: inst_valid = count!=0; head pops on inst_valid&inst_ready. Push and pop in the
//   same cycle leave count unchanged; push into empty FIFO visible on inst_valid next cycle
//   (1-cycle response-to-core latency; no bypass).
//  Redirect (highest priority): same edge flushes FIFO (count=0), fetch_pc=resp_pc=redirect_pc,
//   drop_cnt = outstanding after this cycle's resp (a request cannot be accepted in redirect cycle).
//   Concurrent pop is ignored. inst_valid=0 the cycle after redirect.
//  Counters: count, outstanding, drop_cnt are $clog2(DEPTH)+1 bits; outstanding<=DEPTH, drop_cnt<=outstanding.
//  imem_req_valid may fall without handshake only in a redirect cycle or on FSM change.
//  Memory must return responses in order, at most one per cycle; redirect_pc[1:0] must be 0.
// TESTING
//  1 Reset release, imem ready=1, 1-cycle resp latency, inst_ready=1 -> addrs 0,4,8.. issued;
//    inst_pc 0,4,8 in order, first inst_valid 3 cycles after first request handshake.
//  2 inst_ready=0, imem always ready -> exactly DEPTH=4 requests issued, then imem_req_valid=0;
//    inst_ready=1 one cycle -> pops PC 0, one new request (addr 16) next cycle.
//  3 Three requests outstanding (latency 5), redirect_pc=0x100 -> state FLUSH, no requests,
//    3 responses dropped, then first request addr 0x100; next inst_pc = 0x100.
//  4 Redirect in same cycle as resp_valid and inst_valid&inst_ready -> resp discarded, FIFO
//    empty next cycle, no PC 0x100 duplicate; fetch_pc wraps 0xFFFF_FFFC -> 0x0 with no error.
//  5 Assert rst=0 asynchronously mid-stream (between edges) -> outputs reach reset values
//    immediately; after release first request addr = RESET_PC in BOOT+1 cycle.

Source files
------------

// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue handshake bundle: instruction-memory request/response, core-side
// instruction stream and redirect. master = fetch queue, slave = memory + core.
interface riscv_fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/riscv_fetch_queue.sv
// In-order instruction fetch front end: credit-limited word fetches, a DEPTH-entry
// {pc, inst} FIFO toward the core, and redirect flush with stale-response dropping.
//
//   state | meaning
//   BOOT  | first cycle out of reset, no fetch issued
//   RUN   | fetching and buffering
//   FLUSH | redirect seen with requests in flight; drop them, issue nothing
module riscv_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rst,
    riscv_fetch_queue_if.master bus
);
    localparam int            CW  = $clog2(DEPTH) + 1;
    localparam int            PW  = $clog2(DEPTH);
    localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    logic          credit_ok;
    logic          hs;
    logic          resp;
    logic          push;
    logic          pop;
    logic          redir;
    logic [CW-1:0] stale;
    logic [CW-1:0] drop_nxt;

    // FIFO occupancy plus in-flight requests never exceeds DEPTH, so pushes cannot overflow
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < CAP;
    assign redir     = bus.redirect_valid;
    assign resp      = bus.imem_resp_valid;
    assign hs        = bus.imem_req_valid & bus.imem_req_ready;
    assign push      = resp & (drop_cnt == '0) & ~redir;
    assign pop       = bus.inst_valid & bus.inst_ready & ~redir;
    assign stale     = outstanding - CW'(resp);

    always_comb begin
        drop_nxt = drop_cnt;
        if (redir)
            drop_nxt = stale;
        else if (resp && drop_cnt != '0)
            drop_nxt = drop_cnt - 1'b1;
    end

    assign bus.imem_req_valid = (state == RUN) & ~redir & credit_ok;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (count != '0);
    assign bus.inst_data      = fifo_data[rd_ptr];
    assign bus.inst_pc        = fifo_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(hs) - CW'(resp);
            drop_cnt    <= drop_nxt;
            case (state)
                BOOT:    state <= RUN;
                default: state <= (drop_nxt != '0) ? FLUSH : RUN;
            endcase
            if (hs)
                fetch_pc <= fetch_pc + 32'd4;
            if (redir) begin
                fetch_pc <= bus.redirect_pc;
                resp_pc  <= bus.redirect_pc;
                count    <= '0;
                wr_ptr   <= rd_ptr;
            end else begin
                if (push) begin
                    fifo_data[wr_ptr] <= bus.imem_resp_data;
                    fifo_pc[wr_ptr]   <= resp_pc;
                    wr_ptr            <= wr_ptr + 1'b1;
                    resp_pc           <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: directed vector table, corner-case sequences and a
// randomized run checked against a stream-level model (expected PC / fetch address).
module tb_riscv_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_fetch_queue_if bus();
    riscv_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       memq[$];
    logic [31:0] pop_log[$];
    logic [31:0] hs_log[$];
    int          cyc = 0;
    int          lat = 1;
    bit          rand_lat = 0;
    int          pops = 0;
    logic [31:0] exp_addr, exp_pc;
    bit          prev_redirect;
    logic        s_rv, s_iv, s_resp;
    logic [31:0] s_addr, s_pc, s_data;

    function automatic logic [31:0] qget(input int k, input bit from_hs);
        if (from_hs) return (hs_log.size() > k) ? hs_log[k] : 32'hDEAD_BEEF;
        return (pop_log.size() > k) ? pop_log[k] : 32'hDEAD_BEEF;
    endfunction

    // one clock cycle: drive inputs after the edge, sample mid-cycle, advance model
    task automatic step(input bit rdv, input logic [31:0] rpc, input bit rdy, input bit irdy);
        @(posedge clk);
        cyc++;
        #1;
        bus.redirect_valid = rdv;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = rdy;
        bus.inst_ready     = irdy;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mdata(memq[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end
        #1;
        s_rv   = bus.imem_req_valid;
        s_addr = bus.imem_req_addr;
        s_iv   = bus.inst_valid;
        s_pc   = bus.inst_pc;
        s_data = bus.inst_data;
        s_resp = bus.imem_resp_valid;
        if (prev_redirect) chk("iv_after_redirect", 32'(s_iv), 0);
        if (rdv) chk("req_in_redirect", 32'(s_rv), 0);
        if (s_iv && irdy && !rdv) begin
            chk("pop_pc", s_pc, exp_pc);
            chk("pop_data", s_data, mdata(exp_pc));
            pop_log.push_back(s_pc);
            pops++;
            exp_pc += 32'd4;
        end
        if (s_rv && rdy) begin
            chk("req_addr", s_addr, exp_addr);
            hs_log.push_back(s_addr);
            exp_addr += 32'd4;
        end
        if (rdv) begin
            exp_pc   = rpc;
            exp_addr = rpc;
        end
        if (s_resp) void'(memq.pop_front());
        if (s_rv && rdy) begin
            mreq_t m;
            m.addr = s_addr;
            m.due  = cyc + 1 + (rand_lat ? int'($urandom_range(0, 6)) : lat);
            if (memq.size() > 0 && m.due < memq[$].due) m.due = memq[$].due;
            memq.push_back(m);
        end
        chk("outstanding_bound", 32'(memq.size() <= DEPTH), 1);
        prev_redirect = rdv;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, RESET_PC);
        chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 0);
        chk({tag, "_inst_data"}, bus.inst_data, 0);
        chk({tag, "_inst_pc"}, bus.inst_pc, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        memq.delete();
        hs_log.delete();
        pop_log.delete();
        pops          = 0;
        exp_addr      = RESET_PC;
        exp_pc        = RESET_PC;
        prev_redirect = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("boot_req_valid", 32'(bus.imem_req_valid), 0);
    endtask

    typedef struct { logic rv; logic [31:0] addr; logic iv; logic [31:0] pc; } vec_t;
    vec_t t1[7];

    initial begin
        #1 rst = 1'b0;
        #1 chk_reset("por");

        // steady fetch, 1-cycle memory, core always ready
        t1[0] = '{1'b1, 32'd0,  1'b0, 32'd0};
        t1[1] = '{1'b1, 32'd4,  1'b0, 32'd0};
        t1[2] = '{1'b1, 32'd8,  1'b0, 32'd0};
        t1[3] = '{1'b1, 32'd12, 1'b1, 32'd0};
        t1[4] = '{1'b1, 32'd16, 1'b1, 32'd4};
        t1[5] = '{1'b1, 32'd20, 1'b1, 32'd8};
        t1[6] = '{1'b1, 32'd24, 1'b1, 32'd12};
        do_reset();
        lat = 1;
        for (int i = 0; i < 7; i++) begin
            step(0, '0, 1, 1);
            chk($sformatf("t1_rv[%0d]", i), 32'(s_rv), 32'(t1[i].rv));
            if (t1[i].rv) chk($sformatf("t1_addr[%0d]", i), s_addr, t1[i].addr);
            chk($sformatf("t1_iv[%0d]", i), 32'(s_iv), 32'(t1[i].iv));
            if (t1[i].iv) chk($sformatf("t1_pc[%0d]", i), s_pc, t1[i].pc);
        end

        // core stalled: credit caps fetches at DEPTH
        do_reset();
        begin
            int n = 0;
            for (int i = 0; i < 10; i++) begin
                step(0, '0, 1, 0);
                if (s_rv) n++;
            end
            chk("t2_req_count", n, DEPTH);
            chk("t2_req_stall", 32'(s_rv), 0);
        end
        step(0, '0, 1, 1);
        chk("t2_pop_iv", 32'(s_iv), 1);
        chk("t2_pop_pc", s_pc, 32'd0);
        step(0, '0, 1, 0);
        chk("t2_refill_rv", 32'(s_rv), 1);
        chk("t2_refill_addr", s_addr, 32'd16);

        // redirect with three slow requests in flight
        do_reset();
        lat = 5;
        repeat (3) step(0, '0, 1, 1);
        step(1, 32'h100, 1, 1);
        chk("t3_redirect_rv", 32'(s_rv), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 1, 1);
            chk($sformatf("t3_flush_rv[%0d]", i), 32'(s_rv), 0);
            chk($sformatf("t3_flush_iv[%0d]", i), 32'(s_iv), 0);
        end
        step(0, '0, 1, 1);
        chk("t3_resume_rv", 32'(s_rv), 1);
        chk("t3_resume_addr", s_addr, 32'h100);
        begin
            bit seen = 0;
            logic [31:0] pc0 = '0;
            for (int i = 0; i < 20 && !seen; i++) begin
                step(0, '0, 1, 1);
                if (s_iv) begin seen = 1; pc0 = s_pc; end
            end
            chk("t3_first_iv_seen", 32'(seen), 1);
            chk("t3_first_pc", pc0, 32'h100);
        end

        // redirect colliding with response and pop; then address wrap
        do_reset();
        lat = 1;
        repeat (3) step(0, '0, 1, 1);
        step(1, 32'h100, 1, 1);
        chk("t4_pre_resp", 32'(s_resp), 1);
        chk("t4_pre_iv", 32'(s_iv), 1);
        step(0, '0, 1, 1);
        chk("t4_post_iv", 32'(s_iv), 0);
        chk("t4_post_rv", 32'(s_rv), 0);
        step(0, '0, 1, 1);
        chk("t4_resume_addr", s_rv ? s_addr : 32'hDEAD_BEEF, 32'h100);
        for (int i = 0; i < 20 && pop_log.size() < 2; i++) step(0, '0, 1, 1);
        chk("t4_pop0", qget(0, 0), 32'h100);
        chk("t4_pop1", qget(1, 0), 32'h104);
        step(1, 32'hFFFF_FFF8, 1, 1);
        hs_log.delete();
        pop_log.delete();
        for (int i = 0; i < 30 && (hs_log.size() < 4 || pop_log.size() < 3); i++)
            step(0, '0, 1, 1);
        chk("t4_wrap_req0", qget(0, 1), 32'hFFFF_FFF8);
        chk("t4_wrap_req1", qget(1, 1), 32'hFFFF_FFFC);
        chk("t4_wrap_req2", qget(2, 1), 32'h0000_0000);
        chk("t4_wrap_req3", qget(3, 1), 32'h0000_0004);
        chk("t4_wrap_pop1", qget(1, 0), 32'hFFFF_FFFC);
        chk("t4_wrap_pop2", qget(2, 0), 32'h0000_0000);

        // randomized traffic against the stream model
        do_reset();
        rand_lat = 1;
        for (int i = 0; i < 1500; i++) begin
            bit rdv;
            rdv = ($urandom_range(0, 99) < 3);
            step(rdv, $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70);
        end
        chk("rand_progress", 32'(pops > 100), 1);

        // asynchronous reset between edges
        #1 rst = 1'b0;
        #1 chk_reset("async");
        rand_lat = 0;
        lat = 1;
        do_reset();
        step(0, '0, 1, 1);
        chk("t5_first_rv", 32'(s_rv), 1);
        chk("t5_first_addr", s_addr, RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end
endmodule
